// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
// Optional flush port is enabled by defining UART_TXQ_FLUSH_EN.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        GAPW = 2'd3
    } txq_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy and combinational head read.
// clr empties the FIFO in one cycle and takes priority over push/pop.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus pacing FSM feeding a UART transmitter via send/tx_data/tx_done.
// Define UART_TXQ_FLUSH_EN to add the flush port.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int GAP   = 0,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   send,
    output logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_done,
`ifdef UART_TXQ_FLUSH_EN
    input  logic                   flush,
`endif
    output logic [1:0]             dbg_state
);

    // Handshakes: the host may write whenever full=0 (writes while full are
    // dropped); send is a one-cycle start, tx_data holds until the one-cycle
    // tx_done, and tx_done is only honoured in WAIT.

    txq_state_e             state_q, state_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic [7:0]             gap_cnt_q, gap_cnt_d;
    logic                   send_q, send_d;
    logic                   busy_q, busy_d;
    logic                   overflow_q, overflow_d;
    logic                   flush_w;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic [UART_DATA_W-1:0] fifo_dout;

`ifdef UART_TXQ_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign push = wr_en && !full && !flush_w;
    // A write during flush is discarded silently rather than counted as overflow.
    assign drop = wr_en && full && !flush_w;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush_w),
        .push  (push),
        .pop   (pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        gap_cnt_d  = gap_cnt_q;
        pop        = 1'b0;
        overflow_d = flush_w ? 1'b0 : (overflow_q | drop);
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    tx_data_d = fifo_dout;
                    state_d   = SEND;
                end
            end
            SEND: state_d = WAIT;
            WAIT: begin
                if (tx_done) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP > 0) ? GAPW : IDLE;
                end
            end
            GAPW: begin
                if (gap_cnt_q == 8'(GAP - 1)) state_d = IDLE;
                else gap_cnt_d = gap_cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
        send_d = (state_d == SEND);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            gap_cnt_q  <= '0;
            send_q     <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            gap_cnt_q  <= gap_cnt_d;
            send_q     <= send_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign send      = send_q;
    assign busy      = busy_q;
    assign tx_data   = tx_data_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue (GAP=0 main instance, GAP=3 pacing instance).
// Flush checks run when UART_TXQ_FLUSH_EN is defined.
module tb_uart_tx_queue;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       man_done;
    logic       auto_pulse = 1'b0;
    logic       tx_done;
    logic       tx_done_g;
`ifdef UART_TXQ_FLUSH_EN
    logic       flush;
`endif

    logic       full, empty, overflow, busy, send;
    logic [4:0] count;
    logic [7:0] tx_data;
    logic [1:0] dbg_state;
    logic       full_g, empty_g, overflow_g, busy_g, send_g;
    logic [4:0] count_g;
    logic [7:0] tx_data_g;
    logic [1:0] dbg_state_g;

    int total = 0;
    int bad = 0;
    int sends = 0;
    int auto_cnt = 0;
    logic auto_en = 1'b0;
    logic [7:0] last_sent = 8'h00;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       acc;
        logic [4:0] exp_count;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;
    vec_t vec[17];

    assign tx_done = man_done | auto_pulse;

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH(16), .GAP(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .busy(busy), .send(send), .tx_data(tx_data), .tx_done(tx_done),
`ifdef UART_TXQ_FLUSH_EN
        .flush(flush),
`endif
        .dbg_state(dbg_state)
    );

    uart_tx_queue #(.DEPTH(16), .GAP(3)) dut_g (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_g), .empty(empty_g), .count(count_g), .overflow(overflow_g),
        .busy(busy_g), .send(send_g), .tx_data(tx_data_g), .tx_done(tx_done_g),
`ifdef UART_TXQ_FLUSH_EN
        .flush(flush),
`endif
        .dbg_state(dbg_state_g)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d, input logic expect_sent);
        wr_en   = 1'b1;
        wr_data = d;
        if (expect_sent) exp_q.push_back(d);
        @(negedge clk);
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        auto_en = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
    endtask

    // Scoreboard on send; optional transmitter model answering each send with tx_done.
    always @(negedge clk) begin
        auto_pulse = 1'b0;
        if (auto_cnt > 0) begin
            auto_cnt--;
            if (auto_cnt == 0) begin
                auto_pulse = 1'b1;
                check("held_tx_data", tx_data, last_sent);
            end
        end
        if (!auto_en) auto_cnt = 0;
        if (send) begin
            sends++;
            last_sent = tx_data;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_send: got %0h expected none", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("send_data", tx_data, e);
            end
            if (auto_en) auto_cnt = 3;
        end
    end

    initial begin
        int   k;
        int   s0;
        logic timed_out;

        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; man_done = 1'b0; tx_done_g = 1'b0;
`ifdef UART_TXQ_FLUSH_EN
        flush = 1'b0;
`endif
        for (int i = 0; i < 16; i++) vec[i] = '{8'(i + 1), 1'b1, 5'(i + 1), (i == 15), 1'b0};
        vec[16] = '{8'hFF, 1'b0, 5'd16, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_send", send, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_count_g", count_g, 0);
        rst = 1'b0;

        // Single byte latency: count at N+1, send at N+2, data held.
        write_byte(8'hA5, 1'b1);
        wr_en = 1'b0;
        check("t1_count", count, 1);
        check("t1_no_early_send", send, 0);
        @(negedge clk);
        check("t1_send", send, 1);
        check("t1_tx_data", tx_data, 8'hA5);
        @(negedge clk);
        check("t1_send_one_cycle", send, 0);
        check("t1_busy", busy, 1);
        repeat (3) @(negedge clk);
        check("t1_hold", tx_data, 8'hA5);
        check("t1_sends", sends, 1);

        // Fill while A5 stalls in flight, then overflow with FF.
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1'b1;
            wr_data = vec[i].data;
            if (vec[i].acc) exp_q.push_back(vec[i].data);
            @(negedge clk);
            check("t2_count", count, vec[i].exp_count);
            check("t2_full", full, vec[i].exp_full);
            check("t2_overflow", overflow, vec[i].exp_ovf);
        end
        wr_en = 1'b0;
        auto_en = 1'b1;
        @(negedge clk);
        check("t2_release_data", tx_data, 8'hA5);
        pulse_done();
        timed_out = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (sends == 17 && exp_q.size() == 0 && !busy) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("t2_drain_timeout", timed_out, 0);
        check("t2_sends", sends, 17);
        check("t2_empty", empty, 1);
        check("t2_overflow_sticky", overflow, 1);

        // Write while full coincides with an IDLE pop.
        do_reset();
        for (int i = 0; i < 17; i++) write_byte(8'($urandom_range(0, 255)), 1'b1);
        wr_en = 1'b0;
        check("t3_full", full, 1);
        check("t3_count16", count, 16);
        check("t3_state_wait", dbg_state, WAIT);
        pulse_done();
        write_byte(8'h77, 1'b0);
        wr_en = 1'b0;
        check("t3_count15", count, 15);
        check("t3_overflow", overflow, 1);
        check("t3_send", send, 1);

        // Reset during WAIT with four bytes queued; a late tx_done must not start a send.
        do_reset();
        for (int i = 0; i < 5; i++) write_byte(8'($urandom_range(0, 255)), 1'b1);
        wr_en = 1'b0;
        check("t5_state_wait", dbg_state, WAIT);
        check("t5_count4", count, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("t5_count", count, 0);
        check("t5_busy", busy, 0);
        check("t5_send", send, 0);
        s0 = sends;
        pulse_done();
        repeat (6) @(negedge clk);
        check("t5_no_send", sends, s0);
        check("t5_idle", busy, 0);

        // GAP=3 pacing: second send 5 cycles after first tx_done.
        do_reset();
        auto_en = 1'b1;
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        wr_en = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (send_g) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("t4_first_send_timeout", timed_out, 0);
        check("t4_first_data", tx_data_g, 8'h11);
        repeat (2) @(negedge clk);
        tx_done_g = 1'b1;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            k++;
            if (k == 1) tx_done_g = 1'b0;
            if (send_g) break;
        end
        check("t4_gap_interval", k, 5);
        check("t4_second_data", tx_data_g, 8'h22);
        check("t4_state_send", dbg_state_g, SEND);
        check("t4_empty_g", empty_g, 1);
        check("t4_count_g", count_g, 0);
        check("t4_full_g", full_g, 0);
        check("t4_overflow_g", overflow_g, 0);
        check("t4_busy_g", busy_g, 1);
        repeat (10) @(negedge clk);

`ifdef UART_TXQ_FLUSH_EN
        // Flush during WAIT: FIFO and overflow clear, in-flight byte survives.
        begin
            logic [7:0] first_b;
            do_reset();
            first_b = 8'h3C;
            write_byte(first_b, 1'b1);
            for (int i = 0; i < 16; i++) write_byte(8'($urandom_range(0, 255)), 1'b1);
            write_byte(8'hEE, 1'b0);
            wr_en = 1'b0;
            check("t6_overflow_set", overflow, 1);
            flush = 1'b1;
            write_byte(8'h55, 1'b0);
            flush = 1'b0;
            wr_en = 1'b0;
            exp_q.delete();
            check("t6_count", count, 0);
            check("t6_empty", empty, 1);
            check("t6_overflow_clr", overflow, 0);
            check("t6_busy", busy, 1);
            check("t6_tx_data", tx_data, first_b);
            repeat (3) @(negedge clk);
            check("t6_tx_data_held", tx_data, first_b);
            s0 = sends;
            pulse_done();
            repeat (8) @(negedge clk);
            check("t6_no_send", sends, s0);
            check("t6_idle", busy, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
